// File: rtl/serial_adder.sv
// Bit-serial adder: captures two unsigned operands and a carry-in, then adds
// them one bit per clock (LSB first) through a single full adder. The result
// is presented in registered form together with a one-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  input  logic             i_carry_in,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry_out
);

  // Counter wide enough to index every bit position of an operand.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sumAcc_q, sumAcc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carryOut_q, carryOut_d;

  logic sumBit;
  logic carryNext;
  logic lastBit;
  logic accept;

  // A new request is taken whenever the block is not mid-computation.
  assign accept = i_start && (state_q != BUSY);

  // The bit counter tells us when the MSB is being processed.
  assign lastBit = (count_q == LAST_BIT);

  // Single full adder acting on the current LSBs of the shifting operands.
  assign sumBit    = opA_q[0] ^ opB_q[0] ^ carry_q;
  assign carryNext = (opA_q[0] & opB_q[0]) | (opA_q[0] & carry_q) | (opB_q[0] & carry_q);

  // State register; reset forces IDLE immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE/DONE accept a start, BUSY runs until the MSB.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (lastBit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_start) begin
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs decode directly from the state so reset clears them at once.
  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    case (state_q)
      BUSY:    o_busy = 1'b1;
      DONE:    o_done = 1'b1;
      default: begin
        o_busy = 1'b0;
        o_done = 1'b0;
      end
    endcase
  end

  // Datapath next values: capture on accept, shift/accumulate while busy,
  // load the visible result only on the MSB edge.
  always_comb begin
    opA_d      = opA_q;
    opB_d      = opB_q;
    carry_d    = carry_q;
    count_d    = count_q;
    sumAcc_d   = sumAcc_q;
    sum_d      = sum_q;
    carryOut_d = carryOut_q;

    if (state_q == BUSY) begin
      opA_d             = opA_q >> 1;
      opB_d             = opB_q >> 1;
      carry_d           = carryNext;
      count_d           = count_q + CW'(1);
      sumAcc_d[count_q] = sumBit;
      if (lastBit) begin
        sum_d      = sumAcc_d;
        carryOut_d = carryNext;
      end
    end else if (accept) begin
      opA_d    = i_op1;
      opB_d    = i_op2;
      carry_d  = i_carry_in;
      count_d  = '0;
      sumAcc_d = '0;
    end
  end

  // Datapath registers; reset discards any in-flight work and the last result.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      opA_q      <= '0;
      opB_q      <= '0;
      carry_q    <= 1'b0;
      count_q    <= '0;
      sumAcc_q   <= '0;
      sum_q      <= '0;
      carryOut_q <= 1'b0;
    end else begin
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      carry_q    <= carry_d;
      count_q    <= count_d;
      sumAcc_q   <= sumAcc_d;
      sum_q      <= sum_d;
      carryOut_q <= carryOut_d;
    end
  end

  assign o_sum       = sum_q;
  assign o_carry_out = carryOut_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=4): directed steps plus an
// exhaustive sweep, with expected results queued at the capture edge.
module tb_serial_adder;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int assertCount = 0;
  int failCount   = 0;

  logic [WIDTH:0] scoreboard[$];

  serial_adder #(.WIDTH(WIDTH)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_op1      (op1),
    .i_op2      (op2),
    .i_carry_in (cin),
    .o_busy     (busy),
    .o_done     (done),
    .o_sum      (sum),
    .o_carry_out(cout)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison point: counts it, and counts/reports it on failure.
  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Called just after a falling edge: present a request, let the next rising
  // edge capture it, queue the reference result, and release start.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    logic [WIDTH:0] expected;
    start = 1'b1;
    op1   = a;
    op2   = b;
    cin   = c;
    expected = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    @(posedge clk);
    scoreboard.push_back(expected);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called just after a falling edge: wait (bounded) for o_done, check the
  // number of rising edges it took, scramble operand inputs while waiting,
  // and compare the result against the oldest queued expectation.
  task automatic checkOutput(input string tag, input int expectedEdges);
    int edges;
    logic [WIDTH:0] expected;
    edges = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      edges = k;
      if (done) break;
      if (k < expectedEdges) checkValue({tag, ".busy"}, busy, 1'b1);
      op1 = WIDTH'($urandom);
      op2 = WIDTH'($urandom);
      cin = 1'($urandom);
    end
    if (!done) begin
      assertCount++;
      failCount++;
      $error("[TB] FAIL %s.timeout: observed no done, expected done within 20 cycles", tag);
    end
    checkValue({tag, ".latency"}, edges, expectedEdges);
    checkValue({tag, ".busyAtDone"}, busy, 1'b0);
    if (scoreboard.size() == 0) begin
      assertCount++;
      failCount++;
      $error("[TB] FAIL %s.queue: observed empty scoreboard, expected one entry", tag);
    end else begin
      expected = scoreboard.pop_front();
      checkValue({tag, ".result"}, {cout, sum}, expected);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op1   = '0;
    op2   = '0;
    cin   = 1'b0;

    // Reset state, with start held high to show it is ignored under reset.
    @(negedge clk);
    start = 1'b1;
    op1   = 4'd5;
    op2   = 4'd6;
    repeat (2) @(negedge clk);
    checkValue("reset.busy", busy, 1'b0);
    checkValue("reset.done", done, 1'b0);
    checkValue("reset.sum", sum, '0);
    checkValue("reset.cout", cout, 1'b0);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    checkValue("postReset.idle", busy, 1'b0);

    // Basic add 9+8+0 with exact latency and result hold afterwards.
    applyStimulus(4'd9, 4'd8, 1'b0);
    checkValue("nine8.busyAfterStart", busy, 1'b1);
    checkOutput("nine8", WIDTH);
    @(negedge clk);
    checkValue("nine8.doneOneCycle", done, 1'b0);
    checkValue("nine8.holdSum", {cout, sum}, 5'h11);

    // Corner operands.
    applyStimulus(4'd15, 4'd15, 1'b1);
    checkOutput("max", WIDTH);
    applyStimulus(4'd0, 4'd0, 1'b0);
    checkOutput("zero", WIDTH);

    // A start while busy is ignored and does not queue a second result.
    applyStimulus(4'd3, 4'd4, 1'b0);
    @(negedge clk);
    start = 1'b1;
    op1   = 4'd1;
    op2   = 4'd1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("ignoreStart", WIDTH - 2);
    @(negedge clk);
    checkValue("ignoreStart.noRestart", busy, 1'b0);

    // Back-to-back: second start presented while done is high.
    applyStimulus(4'd3, 4'd4, 1'b0);
    checkOutput("b2bFirst", WIDTH);
    applyStimulus(4'd0, 4'd0, 1'b1);
    checkOutput("b2bSecond", WIDTH);

    // Asynchronous reset mid-computation clears everything, no done follows.
    @(negedge clk);
    applyStimulus(4'd12, 4'd7, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkValue("midReset.busy", busy, 1'b0);
    checkValue("midReset.done", done, 1'b0);
    checkValue("midReset.sum", sum, '0);
    checkValue("midReset.cout", cout, 1'b0);
    #1 rst = 1'b0;
    void'(scoreboard.pop_front());
    begin
      logic sawDone;
      sawDone = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (done || busy) sawDone = 1'b1;
      end
      checkValue("midReset.noLateDone", sawDone, 1'b0);
    end

    // Exhaustive sweep over every operand/carry combination, back-to-back.
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          applyStimulus(WIDTH'(i), WIDTH'(j), 1'(c));
          checkOutput("sweep", WIDTH);
        end
      end
    end

    @(negedge clk);
    checkValue("final.scoreboardEmpty", scoreboard.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
